// File: rtl/mlp_pkg.sv
// Shared types and helpers for the sequential MLP classifier.
// Holds the FSM state encoding, weight-port select codes and the
// functions that derive address and class-index widths from the layer sizes.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    L1,
    L2,
    ARGMAX,
    DONE
  } state_t;

  localparam logic [1:0] SEL_W1 = 2'd0;
  localparam logic [1:0] SEL_B1 = 2'd1;
  localparam logic [1:0] SEL_W2 = 2'd2;
  localparam logic [1:0] SEL_B2 = 2'd3;

  // Bits needed to index n entries (never less than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Weight-port address width: must reach the larger of the two weight matrices.
  function automatic int calc_aw(input int n_in, input int n_hid, input int n_out);
    int m;
    m = n_in * n_hid;
    if (n_hid * n_out > m) m = n_hid * n_out;
    return idx_w(m);
  endfunction

  // Class-index width.
  function automatic int calc_cw(input int n_out);
    return idx_w(n_out);
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Single multiply-accumulate lane shared by both layers.
// Ports: clk/rst, en (operand enable), load_bias (start a new neuron from
// the bias), op_u (unsigned activation, zero-extended), w/bias (signed), acc (registered).
module mlp_mac #(
  parameter int OP_W  = 16,
  parameter int W_W   = 16,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_bias,
  input  logic [OP_W-1:0]         op_u,
  input  logic signed [W_W-1:0]   w,
  input  logic signed [W_W-1:0]   bias,
  output logic signed [ACC_W-1:0] acc
);

  // One extra bit for the zero-extended activation keeps the product exact.
  localparam int P_W = OP_W + W_W + 1;

  logic signed [OP_W:0]      op_s;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   base;

  assign op_s     = $signed({1'b0, op_u});
  assign prod     = P_W'(op_s) * P_W'(w);
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-W_W){bias[W_W-1]}}, bias};

  // First term of a neuron starts from the bias instead of the running sum.
  assign base = load_bias ? bias_ext : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + prod_ext;
    end
  end

endmodule

// File: rtl/mlp_classifier_seq.sv
// Sequential two-layer MLP classifier: y = argmax(relu(x*W1+b1)*W2+b2), one MAC per cycle.
// Ports: x_* pixel stream (valid/ready), w_* weight/bias write port (IDLE only),
// busy, y_* class result (valid held until ready). Optional MLP_SCORE_OUT_EN adds y_score.
module mlp_classifier_seq
  import mlp_pkg::*;
#(
  parameter int N_IN  = 50,
  parameter int N_HID = 20,
  parameter int N_OUT = 10,
  parameter int PIX_W = 10,
  parameter int W_W   = 16,
  parameter int HID_W = 16,
  parameter int ACC_W = 40,
  localparam int AW   = calc_aw(N_IN, N_HID, N_OUT),
  localparam int CW   = calc_cw(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [PIX_W-1:0]        x_data,
  input  logic                    w_wr,
  input  logic [1:0]              w_sel,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic                    busy,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [CW-1:0]           y_class
`ifdef MLP_SCORE_OUT_EN
  ,
  output logic signed [ACC_W-1:0] y_score
`endif
);

  localparam int IW   = idx_w(N_IN);
  localparam int JW   = idx_w(N_HID);
  localparam int KW   = CW;
  localparam int W1AW = idx_w(N_IN * N_HID);
  localparam int W2AW = idx_w(N_HID * N_OUT);
  localparam int OP_W = (PIX_W > HID_W) ? PIX_W : HID_W;

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] HID_MAX = {{(ACC_W-HID_W){1'b0}}, {HID_W{1'b1}}};

  state_t state, state_nxt;

  // i: input index, j: hidden index, k: output index.
  logic [IW-1:0] i_cnt;
  logic [JW-1:0] j_cnt;
  logic [KW-1:0] k_cnt;

  // Register files and weight storage (no reset on data arrays).
  logic [PIX_W-1:0]        x_mem  [N_IN];
  logic [HID_W-1:0]        h_mem  [N_HID];
  logic signed [ACC_W-1:0] s_mem  [N_OUT];
  logic signed [W_W-1:0]   w1_mem [N_IN*N_HID];
  logic signed [W_W-1:0]   b1_mem [N_HID];
  logic signed [W_W-1:0]   w2_mem [N_HID*N_OUT];
  logic signed [W_W-1:0]   b2_mem [N_OUT];

  // The MAC result is registered, so each neuron's final sum is written back
  // one cycle after its last term, overlapping the next neuron's bias load.
  logic            h_wr_pend;
  logic [JW-1:0]   h_wr_idx;
  logic            s_wr_pend;
  logic [KW-1:0]   s_wr_idx;
  logic [HID_W-1:0] h_sat;

  logic signed [ACC_W-1:0] best_val;
  logic [KW-1:0]           best_idx;

  logic                    mac_en;
  logic                    mac_load_bias;
  logic [OP_W-1:0]         mac_op;
  logic signed [W_W-1:0]   mac_w;
  logic signed [W_W-1:0]   mac_bias;
  logic signed [ACC_W-1:0] mac_acc;

  logic [W1AW-1:0] w1_rd;
  logic [W2AW-1:0] w2_rd;
  logic            wr_ok;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (x_valid) state_nxt = LOAD;
      end
      LOAD: begin
        x_ready = 1'b1;
        if (x_valid && i_cnt == I_LAST) state_nxt = L1;
      end
      L1:      if (i_cnt == I_LAST && j_cnt == J_LAST) state_nxt = L2;
      L2:      if (j_cnt == J_LAST && k_cnt == K_LAST) state_nxt = ARGMAX;
      ARGMAX:  if (k_cnt == K_LAST) state_nxt = DONE;
      DONE:    if (y_valid && y_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      h_wr_pend <= 1'b0;
      h_wr_idx  <= '0;
      s_wr_pend <= 1'b0;
      s_wr_idx  <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      y_valid   <= 1'b0;
      y_class   <= '0;
    end else begin
      state     <= state_nxt;
      h_wr_pend <= (state == L1) && (i_cnt == I_LAST);
      h_wr_idx  <= j_cnt;
      s_wr_pend <= (state == L2) && (j_cnt == J_LAST);
      s_wr_idx  <= k_cnt;
      case (state)
        IDLE: begin
          i_cnt <= '0;
          j_cnt <= '0;
          k_cnt <= '0;
        end
        LOAD: begin
          if (x_valid) i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
        end
        L1: begin
          if (i_cnt == I_LAST) begin
            i_cnt <= '0;
            j_cnt <= (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        L2: begin
          if (j_cnt == J_LAST) begin
            j_cnt <= '0;
            k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
          // Strict '>' keeps the lowest index on ties; index 0 seeds the search.
          if (k_cnt == '0 || s_mem[k_cnt] > best_val) begin
            best_val <= s_mem[k_cnt];
            best_idx <= k_cnt;
          end
        end
        DONE: begin
          // First DONE cycle captures the final compare result into the output.
          if (!y_valid) begin
            y_valid <= 1'b1;
            y_class <= best_idx;
          end else if (y_ready) begin
            y_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MLP_SCORE_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      y_score <= '0;
    end else if (state == DONE && !y_valid) begin
      y_score <= best_val;
    end
  end
`endif

  // ---------------------------------------------------------------- datapath
  assign w1_rd = W1AW'(i_cnt) * W1AW'(N_HID) + W1AW'(j_cnt);
  assign w2_rd = W2AW'(j_cnt) * W2AW'(N_OUT) + W2AW'(k_cnt);

  always_comb begin
    mac_en        = 1'b0;
    mac_load_bias = 1'b0;
    mac_op        = '0;
    mac_w         = '0;
    mac_bias      = '0;
    if (state == L1) begin
      mac_en        = 1'b1;
      mac_load_bias = (i_cnt == '0);
      mac_op        = OP_W'(x_mem[i_cnt]);
      mac_w         = w1_mem[w1_rd];
      mac_bias      = b1_mem[j_cnt];
    end else if (state == L2) begin
      mac_en        = 1'b1;
      mac_load_bias = (j_cnt == '0);
      mac_op        = OP_W'(h_mem[j_cnt]);
      mac_w         = w2_mem[w2_rd];
      mac_bias      = b2_mem[k_cnt];
    end
  end

  mlp_mac #(
    .OP_W  (OP_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (mac_en),
    .load_bias (mac_load_bias),
    .op_u      (mac_op),
    .w         (mac_w),
    .bias      (mac_bias),
    .acc       (mac_acc)
  );

  // ReLU followed by saturation to the hidden-activation width.
  always_comb begin
    if (mac_acc[ACC_W-1]) begin
      h_sat = '0;
    end else if (mac_acc > HID_MAX) begin
      h_sat = '1;
    end else begin
      h_sat = mac_acc[HID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && x_valid) x_mem[i_cnt] <= x_data;
    if (h_wr_pend) h_mem[h_wr_idx] <= h_sat;
    if (s_wr_pend) s_mem[s_wr_idx] <= mac_acc;
  end

  // ---------------------------------------------------------------- weight port
  // Writes are accepted only while idle; out-of-range addresses are ignored.
  assign wr_ok = w_wr && (state == IDLE);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (w_sel)
        SEL_W1: if (int'(w_addr) < N_IN * N_HID)  w1_mem[w_addr[W1AW-1:0]] <= w_data;
        SEL_B1: if (int'(w_addr) < N_HID)         b1_mem[w_addr[JW-1:0]]   <= w_data;
        SEL_W2: if (int'(w_addr) < N_HID * N_OUT) w2_mem[w_addr[W2AW-1:0]] <= w_data;
        SEL_B2: if (int'(w_addr) < N_OUT)         b2_mem[w_addr[KW-1:0]]   <= w_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_classifier_seq.sv
module tb_mlp_classifier_seq;
  import mlp_pkg::*;

  localparam int N_IN  = 50;
  localparam int N_HID = 20;
  localparam int N_OUT = 10;
  localparam int PIX_W = 10;
  localparam int W_W   = 16;
  localparam int ACC_W = 40;
  localparam int AW    = 10;
  localparam int CW    = 4;
  localparam int LAT   = N_IN*N_HID + N_HID*N_OUT + N_OUT + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    x_valid;
  logic                    x_ready;
  logic [PIX_W-1:0]        x_data;
  logic                    w_wr;
  logic [1:0]              w_sel;
  logic [AW-1:0]           w_addr;
  logic signed [W_W-1:0]   w_data;
  logic                    busy;
  logic                    y_valid;
  logic                    y_ready;
  logic [CW-1:0]           y_class;
`ifdef MLP_SCORE_OUT_EN
  logic signed [ACC_W-1:0] y_score;
`endif

  mlp_classifier_seq dut (
    .clk     (clk),
    .rst     (rst),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .w_wr    (w_wr),
    .w_sel   (w_sel),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .busy    (busy),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_class (y_class)
`ifdef MLP_SCORE_OUT_EN
    ,
    .y_score (y_score)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int hs_cyc = 0;

  typedef struct {
    int     cls;
    longint score;
    int     bp;
  } exp_t;
  exp_t sb[$];

  int     x_row [N_IN];
  longint w1_m  [N_IN*N_HID];
  longint b1_m  [N_HID];
  longint w2_m  [N_HID*N_OUT];
  longint b2_m  [N_OUT];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic give_up(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic push(input int cls, input longint score, input int bp);
    exp_t e;
    e.cls = cls;
    e.score = score;
    e.bp = bp;
    sb.push_back(e);
  endtask

  // upd=0 issues the write without touching the reference copy (used for writes the DUT must drop).
  task automatic wr(input logic [1:0] sel, input int addr, input int val, input bit upd);
    @(negedge clk);
    w_wr = 1'b1;
    w_sel = sel;
    w_addr = AW'(addr);
    w_data = W_W'(val);
    @(posedge clk);
    #1;
    w_wr = 1'b0;
    if (upd) begin
      case (sel)
        SEL_W1: w1_m[addr] = val;
        SEL_B1: b1_m[addr] = val;
        SEL_W2: w2_m[addr] = val;
        default: b2_m[addr] = val;
      endcase
    end
  endtask

  task automatic load_identity();
    for (int a = 0; a < N_IN*N_HID; a++) wr(SEL_W1, a, (a / N_HID == a % N_HID) ? 1 : 0, 1'b1);
    for (int j = 0; j < N_HID; j++) wr(SEL_B1, j, 0, 1'b1);
    for (int a = 0; a < N_HID*N_OUT; a++) wr(SEL_W2, a, (a / N_OUT == a % N_OUT) ? 1 : 0, 1'b1);
    for (int k = 0; k < N_OUT; k++) wr(SEL_B2, k, 0, 1'b1);
  endtask

  task automatic load_random();
    for (int a = 0; a < N_IN*N_HID; a++) wr(SEL_W1, a, int'($urandom_range(40)) - 20, 1'b1);
    for (int j = 0; j < N_HID; j++) wr(SEL_B1, j, int'($urandom_range(10000)) - 5000, 1'b1);
    for (int a = 0; a < N_HID*N_OUT; a++) wr(SEL_W2, a, int'($urandom_range(2000)) - 1000, 1'b1);
    for (int k = 0; k < N_OUT; k++) wr(SEL_B2, k, int'($urandom_range(20000)) - 10000, 1'b1);
  endtask

  task automatic set_row(input int v);
    for (int i = 0; i < N_IN; i++) x_row[i] = v;
  endtask

  // Streams x_row; gap>0 inserts up to gap idle cycles before each pixel.
  task automatic send_row(input int gap);
    int n;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) begin
      if (gap > 0) begin
        x_valid = 1'b0;
        repeat ($urandom_range(gap)) @(negedge clk);
      end
      x_valid = 1'b1;
      x_data = PIX_W'(x_row[i]);
      n = 0;
      while (!x_ready) begin
        @(negedge clk);
        n++;
        if (n > 5000) give_up("x_ready_wait");
      end
      @(negedge clk);
    end
    hs_cyc = cyc;
    x_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 10000) give_up("drain_wait");
    end
    @(negedge clk);
  endtask

  function automatic void model(output int cls, output longint sc);
    longint h [N_HID];
    longint s [N_OUT];
    longint acc;
    for (int j = 0; j < N_HID; j++) begin
      acc = b1_m[j];
      for (int i = 0; i < N_IN; i++) acc += longint'(x_row[i]) * w1_m[i*N_HID + j];
      h[j] = (acc < 0) ? 0 : ((acc > 65535) ? 65535 : acc);
    end
    for (int k = 0; k < N_OUT; k++) begin
      acc = b2_m[k];
      for (int j = 0; j < N_HID; j++) acc += h[j] * w2_m[j*N_OUT + k];
      s[k] = acc;
    end
    cls = 0;
    for (int k = 1; k < N_OUT; k++) if (s[k] > s[cls]) cls = k;
    sc = s[cls];
  endfunction

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    bit stable;
    logic [CW-1:0] cls0;
    y_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && y_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got class %0d, expected no result", y_class);
          y_ready = 1'b1;
          @(negedge clk);
          y_ready = 1'b0;
        end else begin
          e = sb.pop_front();
          check("class", y_class, e.cls);
`ifdef MLP_SCORE_OUT_EN
          check("score", y_score, e.score);
`endif
          check("latency", cyc - hs_cyc, LAT);
          cls0 = y_class;
          stable = 1'b1;
          repeat (e.bp) begin
            @(negedge clk);
            if (!(y_valid && y_class == cls0)) stable = 1'b0;
          end
          if (e.bp > 0) check("bp_stable", stable, 1);
          y_ready = 1'b1;
          @(negedge clk);
          y_ready = 1'b0;
          check("y_valid_drop", y_valid, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    give_up("watchdog");
  end

  initial begin
    int cls;
    longint sc;
    rst = 1'b1;
    x_valid = 1'b0;
    x_data = '0;
    w_wr = 1'b0;
    w_sel = '0;
    w_addr = '0;
    w_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_y_class", y_class, 0);
`ifdef MLP_SCORE_OUT_EN
    check("rst_y_score", y_score, 0);
`endif
    rst = 1'b0;

    // 1: identity-like network, x[3] dominates.
    load_identity();
    set_row(10);
    x_row[3] = 900;
    push(3, 900, 0);
    send_row(0);
    wait_drain();

    // 2: tie between classes 2 and 7 resolves to the lower index.
    set_row(10);
    x_row[2] = 500;
    x_row[7] = 500;
    push(2, 500, 0);
    send_row(0);
    wait_drain();

    // 3: every hidden neuron clamped by ReLU; only b2[5] is positive.
    for (int j = 0; j < N_HID; j++) wr(SEL_B1, j, -1000, 1'b1);
    wr(SEL_B2, 5, 1, 1'b1);
    set_row(10);
    x_row[3] = 900;
    push(5, 1, 0);
    send_row(0);
    wait_drain();
    for (int j = 0; j < N_HID; j++) wr(SEL_B1, j, 0, 1'b1);
    wr(SEL_B2, 5, 0, 1'b1);

    // 4: result held 50 cycles; writes issued while busy must be dropped.
    set_row(10);
    x_row[7] = 800;
    push(7, 800, 50);
    send_row(0);
    wr(SEL_B2, 0, 30000, 1'b0);
    wr(SEL_W2, 0, 32767, 1'b0);
    wr(SEL_B1, 7, -30000, 1'b0);
    check("busy_in_L1", busy, 1);
    wait_drain();
    push(7, 800, 0);
    send_row(0);
    wait_drain();

    // 5: reset mid-L1 aborts; weights survive.
    set_row(10);
    x_row[9] = 1000;
    send_row(0);
    repeat (300) @(negedge clk);
    check("busy_mid_L1", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_x_ready", x_ready, 0);
    rst = 1'b0;
    push(9, 1000, 0);
    send_row(0);
    wait_drain();

    // 6: random weights, ten back-to-back rows with input gaps.
    load_random();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N_IN; i++) x_row[i] = int'($urandom_range(1023));
      model(cls, sc);
      push(cls, sc, 0);
      send_row(3);
    end
    wait_drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
